// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register pending scoreboard.
// Two combinational read ports with write-back bypass and operand readiness.
module regfile_scoreboard #(
    parameter int REG_LEN  = 32,
    parameter int ADDR_LEN = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_LEN-1:0]  wb_rd_data,
    input  logic [ADDR_LEN-1:0] wb_rd_addr,
    input  logic                wb_rd_enable,
    input  logic [ADDR_LEN-1:0] rs1_addr,
    input  logic                rs1_read_enable,
    output logic [REG_LEN-1:0]  rs1_data,
    output logic                rs1_ready,
    input  logic [ADDR_LEN-1:0] rs2_addr,
    input  logic                rs2_read_enable,
    output logic [REG_LEN-1:0]  rs2_data,
    output logic                rs2_ready,
    input  logic                issue_enable,
    input  logic [ADDR_LEN-1:0] issue_rd_addr,
    input  logic                flush,
    output logic [ADDR_LEN:0]   pending_count
);

    localparam int NREG = 1 << ADDR_LEN;

    logic [REG_LEN-1:0]  r_regs [NREG];
    logic [NREG-1:0]     r_pend;
    logic [ADDR_LEN:0]   r_pendingCount;
    logic [NREG-1:0]     w_pendNext;
    logic [ADDR_LEN:0]   w_countNext;
    logic                w_wbValid;

    assign w_wbValid = wb_rd_enable && (wb_rd_addr != '0);

    // Issue is applied after write-back so a new producer keeps the register pending.
    always_comb begin
        w_pendNext = r_pend;
        if (flush) begin
            w_pendNext = '0;
        end else begin
            if (w_wbValid)
                w_pendNext[wb_rd_addr] = 1'b0;
            if (issue_enable && (issue_rd_addr != '0))
                w_pendNext[issue_rd_addr] = 1'b1;
        end
        w_pendNext[0] = 1'b0;
    end

    always_comb begin
        w_countNext = '0;
        for (int i = 0; i < NREG; i++)
            w_countNext = w_countNext + (ADDR_LEN+1)'(w_pendNext[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend         <= '0;
            r_pendingCount <= '0;
        end else begin
            r_pend         <= w_pendNext;
            r_pendingCount <= w_countNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_wbValid) begin
            r_regs[wb_rd_addr] <= wb_rd_data;
        end
    end

    assign pending_count = r_pendingCount;

    always_comb begin
        rs1_data  = '0;
        rs1_ready = 1'b1;
        if (rs1_read_enable && (rs1_addr != '0)) begin
            if (wb_rd_enable && (wb_rd_addr == rs1_addr)) begin
                rs1_data = wb_rd_data;
            end else begin
                rs1_data  = r_regs[rs1_addr];
                rs1_ready = !r_pend[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data  = '0;
        rs2_ready = 1'b1;
        if (rs2_read_enable && (rs2_addr != '0)) begin
            if (wb_rd_enable && (wb_rd_addr == rs2_addr)) begin
                rs2_data = wb_rd_data;
            end else begin
                rs2_data  = r_regs[rs2_addr];
                rs2_ready = !r_pend[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [31:0] wb_rd_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_enable;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_read_enable, rs2_read_enable;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_ready, rs2_ready;
    logic        issue_enable;
    logic [4:0]  issue_rd_addr;
    logic        flush;
    logic [5:0]  pending_count;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.REG_LEN(32), .ADDR_LEN(5)) dut (
        .clk(clk), .rst(rst),
        .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
        .rs1_addr(rs1_addr), .rs1_read_enable(rs1_read_enable),
        .rs1_data(rs1_data), .rs1_ready(rs1_ready),
        .rs2_addr(rs2_addr), .rs2_read_enable(rs2_read_enable),
        .rs2_data(rs2_data), .rs2_ready(rs2_ready),
        .issue_enable(issue_enable), .issue_rd_addr(issue_rd_addr),
        .flush(flush), .pending_count(pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Moves to 1 time unit after the next rising edge, with all strobes idle.
    task automatic stepIdle();
        @(posedge clk);
        #1;
        wb_rd_enable = 1'b0;
        issue_enable = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic applyStimulus(input logic wbEn, input logic [4:0] wbAddr, input logic [31:0] wbData,
                                 input logic isEn, input logic [4:0] isAddr, input logic fl);
        wb_rd_enable  = wbEn;
        wb_rd_addr    = wbAddr;
        wb_rd_data    = wbData;
        issue_enable  = isEn;
        issue_rd_addr = isAddr;
        flush         = fl;
    endtask

    task automatic setReads(input logic [4:0] a1, input logic [4:0] a2);
        rs1_read_enable = 1'b1;
        rs2_read_enable = 1'b1;
        rs1_addr        = a1;
        rs2_addr        = a2;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        rs1_read_enable = 1'b0;
        rs2_read_enable = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;

        // Reset state before any clock edge
        #2;
        setReads(5'd5, 5'd31);
        checkOutput("reset_count", pending_count, 0);
        checkOutput("reset_rs1_data", rs1_data, 0);
        checkOutput("reset_rs1_ready", rs1_ready, 1);
        checkOutput("reset_rs2_ready", rs2_ready, 1);
        rst = 1'b0;
        stepIdle();

        // Writes to x0 are dropped and never bypassed
        applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0);
        setReads(5'd0, 5'd0);
        checkOutput("x0_same_cycle_data", rs1_data, 0);
        stepIdle();
        setReads(5'd0, 5'd0);
        checkOutput("x0_data", rs1_data, 0);
        checkOutput("x0_ready", rs2_ready, 1);
        checkOutput("x0_issue_count", pending_count, 0);

        // Write with bypass, then from array
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0);
        setReads(5'd5, 5'd6);
        checkOutput("bypass_data", rs1_data, 32'h12345678);
        checkOutput("bypass_ready", rs1_ready, 1);
        checkOutput("no_bypass_other", rs2_data, 0);
        stepIdle();
        setReads(5'd5, 5'd5);
        checkOutput("array_rs1_data", rs1_data, 32'h12345678);
        checkOutput("array_rs2_data", rs2_data, 32'h12345678);
        rs1_read_enable = 1'b0;
        #1;
        checkOutput("disabled_rs1_data", rs1_data, 0);
        checkOutput("disabled_rs1_ready", rs1_ready, 1);

        // RAW stall on x7
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        setReads(5'd7, 5'd7);
        checkOutput("issue_same_cycle_ready", rs1_ready, 1);
        stepIdle();
        setReads(5'd7, 5'd7);
        checkOutput("raw_ready", rs1_ready, 0);
        checkOutput("raw_count", pending_count, 1);
        applyStimulus(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 1'b0);
        setReads(5'd7, 5'd7);
        checkOutput("wb_bypass_data", rs1_data, 32'hA5);
        checkOutput("wb_bypass_ready", rs1_ready, 1);
        checkOutput("wb_count_before_edge", pending_count, 1);
        stepIdle();
        setReads(5'd7, 5'd7);
        checkOutput("wb_count_after", pending_count, 0);
        checkOutput("wb_ready_after", rs2_ready, 1);

        // Simultaneous issue and write-back to x9: set dominates
        applyStimulus(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 1'b0);
        stepIdle();
        setReads(5'd9, 5'd9);
        checkOutput("x9_data", rs1_data, 1);
        checkOutput("x9_ready", rs1_ready, 0);
        checkOutput("x9_count", pending_count, 1);
        applyStimulus(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 1'b0);
        stepIdle();
        checkOutput("x9_cleared_count", pending_count, 0);

        // Flush squashes reservations and same-cycle issue, keeps write-back
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b0);
            stepIdle();
        end
        checkOutput("three_pending_count", pending_count, 3);
        applyStimulus(1'b1, 5'd1, 32'h55, 1'b1, 5'd4, 1'b1);
        stepIdle();
        setReads(5'd4, 5'd1);
        checkOutput("flush_count", pending_count, 0);
        checkOutput("flush_x4_ready", rs1_ready, 1);
        checkOutput("flush_x1_data", rs2_data, 32'h55);
        setReads(5'd2, 5'd3);
        checkOutput("flush_x2_ready", rs1_ready, 1);

        // Asynchronous reset mid-operation with five reservations
        for (int i = 10; i <= 14; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b0);
            stepIdle();
        end
        checkOutput("five_pending_count", pending_count, 5);
        setReads(5'd12, 5'd5);
        checkOutput("pre_reset_x12_ready", rs1_ready, 0);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_count", pending_count, 0);
        setReads(5'd5, 5'd7);
        checkOutput("async_reset_x5", rs1_data, 0);
        checkOutput("async_reset_x7", rs2_data, 0);
        setReads(5'd12, 5'd1);
        checkOutput("async_reset_x12_ready", rs1_ready, 1);
        checkOutput("async_reset_x1", rs2_data, 0);
        rst = 1'b0;
        stepIdle();
        setReads(5'd12, 5'd5);
        checkOutput("post_reset_count", pending_count, 0);
        checkOutput("post_reset_x5", rs2_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural integer register file with a per-register pending scoreboard, the write-back end of the MEM/WB pipeline register. It accepts the write-back write port (`wb_rd_data`, `wb_rd_addr`, `wb_rd_enable`) and serves two combinational read ports to the decode stage. Each read port reports operand readiness, with write-back bypass, so decode can stall on unresolved RAW hazards. Decode marks destinations pending at issue, write-back clears them, and a pipeline flush squashes all outstanding reservations.

## Interface
- `REG_LEN`, 32, register data width (matches `` `RegLen ``)
- `ADDR_LEN`, 5, register address width (matches `` `RegAddrLen ``); 2^ADDR_LEN registers
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high (`` `ResetEnable `` = 1)
- `wb_rd_data`  in  REG_LEN  write-back data
- `wb_rd_addr`  in  ADDR_LEN  write-back destination register
- `wb_rd_enable`  in  1  write-back strobe (`` `WriteEnable ``)
- `rs1_addr`, `rs2_addr`  in  ADDR_LEN  read addresses
- `rs1_read_enable`, `rs2_read_enable`  in  1  read port enables
- `rs1_data`, `rs2_data`  out  REG_LEN  read data, combinational
- `rs1_ready`, `rs2_ready`  out  1  operand valid this cycle, combinational
- `issue_enable`  in  1  decode issues an instruction that writes `issue_rd_addr`
- `issue_rd_addr`  in  ADDR_LEN  destination being reserved
- `flush`  in  1  squash all pending reservations
- `pending_count`  out  ADDR_LEN+1  registered count of set pending bits

## Operation
- State: register array `regs[0..2^ADDR_LEN-1]`, pending vector `pend[]`, register `pending_count`.
- Register 0 is hardwired:
  - reads return 0 and ready=1;
  - writes to it are dropped;
  - issues to it are ignored;
  - `pend[0]` is always 0.
- Read port n (evaluated in priority order):
  1. `rsn_read_enable`=0: data=0, ready=1.
  2. addr=0: data=0, ready=1.
  3. `wb_rd_enable`=1, `wb_rd_addr`=addr: data=`wb_rd_data` (bypass), ready=1.
  4. Otherwise: data=`regs[addr]`, ready=`!pend[addr]`.
- Write: on the edge with `wb_rd_enable`=1 and addr≠0, `regs[addr]`<=data and `pend[addr]` is cleared.
- Issue: on the edge with `issue_enable`=1, addr≠0 and `flush`=0, `pend[addr]` is set.
  - Set dominates clear when issue and write-back target the same register in the same cycle, because a new producer is in flight.
  - Issue to an already-pending register leaves it pending (single bit; in-order pipeline guarantees WAW order).
- Flush: on the edge, all `pend` bits are cleared and any same-cycle issue is dropped. A same-cycle write-back still commits to `regs`.
- `pending_count` <= popcount of the next-state `pend` vector. Range 0..2^ADDR_LEN-1, no wrap possible.

## Timing
- Reset (asynchronous, immediate, independent of `clk`):
  - all `regs` = 0, all `pend` = 0, `pending_count` = 0.
  - Combinational outputs then give data=0, ready=1 on every port, except when a bypass hit supplies `wb_rd_data`.
- Reset asserted mid-operation discards all in-flight reservations and register contents. The first edge after deassertion performs normal updates.
- Read latency: 0 cycles, purely combinational from addresses and write-back inputs.
- Write latency: data is visible via bypass in the write-back cycle and from the array starting the next cycle.
- Issue latency: the reserved register reads not-ready starting the cycle after `issue_enable`. A same-cycle read of that register sees the pre-edge state.
- `pending_count` updates 1 cycle after the causing event.
- Both read ports are independent; the same address on both ports returns identical data/ready.

## Test plan
- **Reset and x0:**
  - Stimulus: assert `rst` between edges.
  - Required: `pending_count`=0 immediately and all reads return 0/ready=1.
  - Stimulus: write 0xDEADBEEF to x0, then read x0.
  - Required: x0 reads 0, ready=1.
- **Write/read and bypass:**
  - Stimulus: write x5=0x12345678; in the same cycle read rs1=x5.
  - Required: rs1 gives 0x12345678 via bypass.
  - Required: the next cycle, with `wb_rd_enable`=0, still gives 0x12345678 from the array.
- **RAW stall:**
  - Stimulus: issue x7, then read x7.
  - Required: next cycle `rs1_ready`=0 and `pending_count`=1.
  - Stimulus: write-back x7=0xA5.
  - Required: that cycle reads 0xA5 with ready=1; the following cycle `pending_count`=0.
- **Simultaneous issue and write-back to x9:**
  - Stimulus: issue x9 and write-back x9=0x1 in the same cycle.
  - Required: next cycle `regs[9]`=1 and x9 still not ready, `pending_count`=1.
- **Flush:**
  - Stimulus: issue x1, x2, x3 on three cycles.
  - Required: `pending_count`=3.
  - Stimulus: assert `flush` together with issue x4 and write-back x1=0x55.
  - Required: next cycle `pending_count`=0, x4 ready, x1 reads 0x55.
- **Async reset mid-operation:**
  - Stimulus: with 5 pending registers, pulse `rst` between clock edges.
  - Required: `pending_count` drops to 0 immediately without an edge, and all registers read 0.
